// File: rtl/usb_pkg.sv
// Shared constants, state encoding and CRC helper
// for the USB low-level packet transmitter.
package usb_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK = 8'hD2;
  localparam logic [7:0] PID_NAK = 8'h5A;

  localparam logic [15:0] CRC_POLY = 16'h8005;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam logic [6:0] MAX_PAYLOAD = 7'd64;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_DATA0,
    REQ_ACK,
    REQ_NAK
  } tx_req_t;

  typedef enum logic [3:0] {
    IDLE,
    SYNC,
    PID,
    LOAD_DATA,
    DATA,
    CRC_LO,
    CRC_HI,
    EOP_SE0,
    EOP_J
  } tx_state_t;

  function automatic logic [7:0] pid_byte(
    input tx_req_t req
  );
    case (req)
      REQ_DATA0: return PID_DATA0;
      REQ_ACK:   return PID_ACK;
      REQ_NAK:   return PID_NAK;
      default:   return 8'h00;
    endcase
  endfunction

  // LSB-first bits shift right, so the
  // polynomial is applied bit-reversed.
  function automatic logic [15:0] crc16_step(
    input logic [15:0] crc,
    input logic        b
  );
    logic [15:0] rpoly;
    for (int i = 0; i < 16; i++)
      rpoly[i] = CRC_POLY[15-i];
    if (crc[0] ^ b)
      return (crc >> 1) ^ rpoly;
    return crc >> 1;
  endfunction

endpackage

// File: rtl/usb_tx_encoder.sv
// Bit-period timer, NRZI line register and
// bit stuffing for the USB transmitter.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic run,
  input  logic start,
  input  logic din,
  input  logic se0,
  input  logic force_j,
  output logic adv,
  output logic dplus,
  output logic dminus
);

  localparam int TW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST =
    TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] timer;
  logic [2:0] ones;
  logic apply;
  logic stuff;

  // apply: a new bit period begins this edge
  assign apply = start || (run && timer == LAST);
  assign stuff = (ones == 3'd6);
  assign adv = apply && !stuff;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer  <= '0;
      ones   <= '0;
      dplus  <= 1'b1;
      dminus <= 1'b0;
    end else if (!run && !start) begin
      timer  <= '0;
      ones   <= '0;
      dplus  <= 1'b1;
      dminus <= 1'b0;
    end else begin
      timer <= apply ? '0 : timer + TW'(1);
      if (apply) begin
        if (stuff) begin
          dplus  <= ~dplus;
          dminus <= dplus;
          ones   <= '0;
        end else if (se0) begin
          dplus  <= 1'b0;
          dminus <= 1'b0;
          ones   <= '0;
        end else if (force_j) begin
          dplus  <= 1'b1;
          dminus <= 1'b0;
          ones   <= '0;
        end else if (din) begin
          ones <= ones + 3'd1;
        end else begin
          dplus  <= ~dplus;
          dminus <= dplus;
          ones   <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/usb_tx_packet.sv
// USB packet transmitter: SYNC, PID, payload,
// CRC16 and EOP sequencing over the encoder.
module usb_tx_packet #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] tx_packet,
  input  logic [7:0] tx_data,
  input  logic [6:0] buffer_occupancy,
  output logic       get_tx_packet_data,
  output logic       tx_transfer_active,
  output logic       tx_error,
  output logic       dplus_out,
  output logic       dminus_out
);

  import usb_pkg::*;

  tx_state_t state;
  tx_req_t req;
  logic [7:0] shreg;
  logic [7:0] pid;
  logic [2:0] bitcnt;
  logic [6:0] bytecnt;
  logic [15:0] crc;

  logic start;
  logic run;
  logic adv;
  logic din;
  logic se0;
  logic force_j;

  assign start = (state == IDLE) && (tx_packet != 2'd0);
  assign run = (state != IDLE);
  assign se0 = (state == EOP_SE0);
  assign force_j = (state == EOP_J);
  // shreg always holds the next bit to go out
  assign din = (state == IDLE) ? SYNC_BYTE[0] : shreg[0];

  usb_tx_encoder #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_enc (
    .clk     (clk),
    .n_rst   (n_rst),
    .run     (run),
    .start   (start),
    .din     (din),
    .se0     (se0),
    .force_j (force_j),
    .adv     (adv),
    .dplus   (dplus_out),
    .dminus  (dminus_out)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state              <= IDLE;
      req                <= REQ_NONE;
      shreg              <= SYNC_BYTE;
      pid                <= 8'h00;
      bitcnt             <= '0;
      bytecnt            <= '0;
      crc                <= CRC_INIT;
      get_tx_packet_data <= 1'b0;
      tx_transfer_active <= 1'b0;
      tx_error           <= 1'b0;
    end else begin
      get_tx_packet_data <= 1'b0;
      tx_error <= run && (tx_packet != 2'd0);
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= SYNC;
            req     <= tx_req_t'(tx_packet);
            pid     <= pid_byte(tx_req_t'(tx_packet));
            shreg   <= SYNC_BYTE >> 1;
            bitcnt  <= 3'd1;
            bytecnt <= '0;
            crc     <= CRC_INIT;
            tx_transfer_active <= 1'b1;
          end
        end
        SYNC, PID, DATA, CRC_LO, CRC_HI: begin
          if (adv) begin
            if (state == DATA)
              crc <= crc16_step(crc, shreg[0]);
            shreg  <= shreg >> 1;
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              unique case (state)
                SYNC: begin
                  state <= PID;
                  shreg <= pid;
                end
                PID:
                  state <= (req == REQ_DATA0) ?
                    LOAD_DATA : EOP_SE0;
                DATA:
                  state <= LOAD_DATA;
                CRC_LO: begin
                  state <= CRC_HI;
                  shreg <= ~crc[15:8];
                end
                default:
                  state <= EOP_SE0;
              endcase
            end
          end
        end
        LOAD_DATA: begin
          // one clock, well inside the last bit period
          if (bytecnt != MAX_PAYLOAD &&
              buffer_occupancy != 7'd0) begin
            get_tx_packet_data <= 1'b1;
            shreg   <= tx_data;
            bytecnt <= bytecnt + 7'd1;
            state   <= DATA;
          end else begin
            shreg <= ~crc[7:0];
            state <= CRC_LO;
          end
        end
        EOP_SE0: begin
          if (adv) begin
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt[0]) begin
              bitcnt <= '0;
              state  <= EOP_J;
            end
          end
        end
        EOP_J: begin
          // first adv puts J on the line, second ends it
          if (adv) begin
            bitcnt <= 3'd1;
            if (bitcnt[0]) begin
              bitcnt <= '0;
              shreg  <= SYNC_BYTE;
              state  <= IDLE;
              tx_transfer_active <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_packet.sv
// Self-checking bench for usb_tx_packet against a
// bit-list / stuffing / NRZI reference model.
module tb_usb_tx_packet;

  localparam int CPB = 8;
  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [1:0] tx_packet = 2'd0;
  logic [7:0] tx_data;
  logic [6:0] buffer_occupancy;
  logic get_tx_packet_data;
  logic tx_transfer_active;
  logic tx_error;
  logic dplus_out;
  logic dminus_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] buf_mem [0:127];
  int buf_len = 0;
  int rd_ptr = 0;
  logic buf_clr = 1'b0;
  int err_pulses = 0;

  bit ebits[$];
  logic [1:0] eline[$];

  always #5 clk = ~clk;

  usb_tx_packet #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_packet          (tx_packet),
    .tx_data            (tx_data),
    .buffer_occupancy   (buffer_occupancy),
    .get_tx_packet_data (get_tx_packet_data),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .dplus_out          (dplus_out),
    .dminus_out         (dminus_out)
  );

  assign tx_data = buf_mem[rd_ptr[6:0]];
  assign buffer_occupancy = ((buf_len - rd_ptr) > 64) ?
    7'd64 : 7'(buf_len - rd_ptr);

  always @(posedge clk) begin
    if (buf_clr) rd_ptr <= 0;
    else if (get_tx_packet_data) rd_ptr <= rd_ptr + 1;
    if (tx_error) err_pulses <= err_pulses + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) ebits.push_back(b[i]);
  endfunction

  // CRC-16/USB computed bytewise over the buffer
  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      c = c ^ {8'h00, buf_mem[k]};
      for (int j = 0; j < 8; j++)
        c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input logic [1:0] req, input int n);
    logic [1:0] lvl;
    logic [15:0] c;
    int ones;
    int nb;
    ebits.delete();
    eline.delete();
    push_byte(8'h80);
    case (req)
      2'd1: push_byte(8'hC3);
      2'd2: push_byte(8'hD2);
      default: push_byte(8'h5A);
    endcase
    if (req == 2'd1) begin
      nb = (n > 64) ? 64 : n;
      for (int k = 0; k < nb; k++) push_byte(buf_mem[k]);
      c = ref_crc(nb);
      push_byte(c[7:0]);
      push_byte(c[15:8]);
    end
    lvl = LJ;
    ones = 0;
    foreach (ebits[i]) begin
      if (!ebits[i]) lvl = (lvl == LJ) ? LK : LJ;
      eline.push_back(lvl);
      ones = ebits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        lvl = (lvl == LJ) ? LK : LJ;
        eline.push_back(lvl);
        ones = 0;
      end
    end
    eline.push_back(LSE0);
    eline.push_back(LSE0);
    eline.push_back(LJ);
  endtask

  task automatic load_buf(input int n, input bit all_ones);
    for (int i = 0; i < n; i++)
      buf_mem[i] = all_ones ? 8'hFF : 8'($urandom);
    buf_len = n;
    buf_clr = 1'b1;
    @(posedge clk);
    #1 buf_clr = 1'b0;
  endtask

  // inj >= 1 drives a stray ACK request one clock
  // into the gap before symbol inj
  task automatic send(input string tag,
                      input logic [1:0] req,
                      input int n,
                      input int inj);
    int p0;
    int e0;
    int exp_pops;
    build(req, n);
    exp_pops = (req == 2'd1) ? ((n > 64) ? 64 : n) : 0;
    p0 = rd_ptr;
    e0 = err_pulses;
    tx_packet = req;
    @(posedge clk);
    #1 tx_packet = 2'd0;
    chk({tag, " active_rise"}, tx_transfer_active, 1);
    for (int i = 0; i < eline.size(); i++) begin
      if (i == 0) begin
        repeat (CPB / 2) @(posedge clk);
      end else if (i == inj) begin
        tx_packet = 2'd2;
        @(posedge clk);
        #1 tx_packet = 2'd0;
        chk({tag, " tx_error"}, tx_error, 1);
        repeat (CPB - 1) @(posedge clk);
      end else begin
        repeat (CPB) @(posedge clk);
      end
      #1;
      chk($sformatf("%s line%0d", tag, i),
          {dplus_out, dminus_out}, eline[i]);
    end
    repeat (CPB / 2 - 1) @(posedge clk);
    #1 chk({tag, " active_last"}, tx_transfer_active, 1);
    @(posedge clk);
    #1;
    chk({tag, " active_fall"}, tx_transfer_active, 0);
    chk({tag, " idle_j"}, {dplus_out, dminus_out}, LJ);
    chk({tag, " pops"}, rd_ptr - p0, exp_pops);
    chk({tag, " err_cnt"}, err_pulses - e0,
        (inj > 0) ? 1 : 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst line", {dplus_out, dminus_out}, LJ);
    chk("rst active", tx_transfer_active, 0);
    chk("rst pop", get_tx_packet_data, 0);
    chk("rst err", tx_error, 0);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk);
    #1;

    send("ack", 2'd2, 0, -1);
    send("nak_b2b", 2'd3, 0, -1);

    load_buf(0, 1'b0);
    send("d0_empty", 2'd1, 0, -1);

    load_buf(2, 1'b1);
    send("d0_ffff", 2'd1, 2, -1);

    load_buf(5, 1'b0);
    send("d0_err", 2'd1, 5, 30);

    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 12);
      load_buf(n, 1'b0);
      send($sformatf("d0_rand%0d", k), 2'd1, n, -1);
    end

    load_buf(70, 1'b0);
    send("d0_cap", 2'd1, 70, -1);

    load_buf(10, 1'b0);
    tx_packet = 2'd1;
    @(posedge clk);
    #1 tx_packet = 2'd0;
    repeat (24 * CPB + 3) @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    chk("abort line", {dplus_out, dminus_out}, LJ);
    chk("abort active", tx_transfer_active, 0);
    chk("abort pop", get_tx_packet_data, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort hold", {dplus_out, dminus_out}, LJ);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk);
    #1;
    send("ack_after_rst", 2'd2, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_tx_packet.md
USB_TX_PACKET -- requirements
Module: usb_tx_packet

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 8, clocks per transmitted bit period.
REQ-002 clk  input  1  system clock, rising-edge active.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 tx_packet  input  2  request: 0 none, 1 DATA0, 2 ACK, 3 NAK; sampled only in IDLE.
REQ-005 tx_data  input  8  next payload byte from the transmit buffer.
REQ-006 buffer_occupancy  input  7  payload bytes available in the buffer, 0..64.
REQ-007 get_tx_packet_data  output  1  one-clock pop strobe to the buffer.
REQ-008 tx_transfer_active  output  1  high from request acceptance through the end of EOP.
REQ-009 tx_error  output  1  one-clock pulse on a rejected request.
REQ-010 dplus_out  output  1  encoded D+ line.
REQ-011 dminus_out  output  1  encoded D- line.

Function
REQ-012 Idle bus SHALL be J (dplus_out=1, dminus_out=0); K is (0,1); SE0 is (0,0).
REQ-013 FSM states SHALL be IDLE, SYNC, PID, LOAD_DATA, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J.
REQ-014 IDLE with tx_packet!=0 SHALL accept the request; tx_transfer_active rises the next clock, which also starts the first SYNC bit period.
REQ-015 Bits SHALL be sent LSB first, each held for exactly CLKS_PER_BIT clocks.
REQ-016 SYNC byte SHALL be 8'h80; PID bytes SHALL be DATA0 8'hC3, ACK 8'hD2, NAK 8'h5A.
REQ-017 ACK/NAK SHALL go PID -> EOP_SE0 directly.
REQ-018 DATA0 SHALL go PID -> LOAD_DATA; LOAD_DATA with buffer_occupancy>0 SHALL pulse get_tx_packet_data for one clock, latch tx_data that clock, and enter DATA; with occupancy 0 it SHALL enter CRC_LO.
REQ-019 After the 8th bit of a DATA byte the FSM SHALL return to LOAD_DATA; payload is capped at 64 bytes, after which it SHALL enter CRC_LO regardless of occupancy.
REQ-020 CRC16 SHALL use polynomial 0x8005, init 16'hFFFF, updated LSB first over payload bits only; the transmitted value is the ones-complement remainder, low byte then high byte, each LSB first.
REQ-021 NRZI: data 0 toggles the line between J and K; data 1 holds it; the first SYNC bit is referenced to J.
REQ-022 Bit stuffing: after six consecutive 1s (counted from the start of SYNC through the last CRC bit) one extra 0 bit period SHALL be inserted; it does not advance the shift register or CRC, and it resets the ones counter.
REQ-023 EOP SHALL be two bit periods of SE0 followed by one bit period of J, then IDLE; tx_transfer_active falls on entry to IDLE.
REQ-024 No stuff bit SHALL be inserted during EOP.
REQ-025 tx_packet!=0 while not in IDLE SHALL be ignored and SHALL pulse tx_error for one clock, with no effect on the packet in flight.
REQ-026 Back-to-back: a request present on the clock of entering IDLE SHALL be accepted the following clock.

Reset
REQ-027 While n_rst=0: state IDLE, line J, tx_transfer_active=0, get_tx_packet_data=0, tx_error=0, bit timer, stuff counter and byte counter cleared, CRC register=16'hFFFF.
REQ-028 Reset mid-packet SHALL abort immediately to J with no EOP, and must not pop the buffer.

Structure
REQ-029 Shared package usb_pkg SHALL hold the PID constants, SYNC value, CRC polynomial/init and the state enum.
REQ-030 One sub-module, usb_tx_encoder, SHALL hold the bit timer, NRZI register and stuffing logic; it issues a bit-advance strobe to the FSM and accepts SE0/J forcing.

Verification
REQ-031 ACK request, CLKS_PER_BIT=8 -> line per bit K J K J K J K K, then J J K J J K K K, then SE0 SE0 J; active for 19 bit periods (152 clocks).
REQ-032 NAK request -> PID bits LSB first 0,1,0,1,1,0,1,0 are NRZI-encoded after SYNC; SE0 appears exactly at bit period 17.
REQ-033 DATA0 with occupancy 0 -> SYNC, C3, CRC bytes 8'h00, 8'h00, EOP; get_tx_packet_data is never asserted.
REQ-034 DATA0, payload 8'hFF 8'hFF -> one stuffed 0 after each 6 consecutive ones; exactly 2 pops; CRC matches a reference model.
REQ-035 tx_packet=2 during DATA0 transmission -> one tx_error pulse; the DATA0 waveform is unchanged.
REQ-036 n_rst low during the DATA state -> line J, tx_transfer_active=0 within the reset; a new ACK after release transmits cleanly.
